// File: rtl/convertidor_32a8.sv
// convertidor_32a8: 32-to-8 unpacker that emits a word as 1, 2 or 4 bytes, LSB first.
// Width is selected per word by PCLK, which is sampled when the word is accepted.
// Storage is one current-word register and one pending slot, so words can follow
// each other with no gap between them.
// Ports:
//   CLK, RESET (async, active high), ENB (stage enable, low = full stall)
//   PCLK[1:0]      width select: 00=1 byte, 01=2, 10=4, 11=4
//   in_data[31:0]  input word, byte k = in_data[8k+7:8k]
//   in_valid       in_data holds a word
//   in_ready       combinational, ENB & ~pend_v
//   out_data[7:0]  registered output byte
//   out_valid      registered, out_data holds a valid byte
//   out_bit[1:0]   registered index k of the byte on out_data
//                  (named out_bit because "bit" is a reserved word)
//   out_par        only with CONV328_PARIDAD_EN: registered XOR of out_data
// Optional feature macro: CONV328_PARIDAD_EN.
module convertidor_32a8 (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENB,
    input  logic [1:0]  PCLK,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic [1:0]  out_bit
`ifdef CONV328_PARIDAD_EN
    ,
    output logic        out_par
`endif
);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cur_q, cur_d;
    logic [1:0]  n_q, n_d;
    logic [31:0] pend_q, pend_d;
    logic [1:0]  pend_n_q, pend_n_d;
    logic        pend_v_q, pend_v_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic [1:0]  bit_q, bit_d;
    logic        accept;

    // Index of the last byte for a width select; 11 behaves like 10.
    function automatic logic [1:0] last_idx(input logic [1:0] sel);
        logic [1:0] r;
        case (sel)
            2'b00:   r = 2'd0;
            2'b01:   r = 2'd1;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w,
                                            input logic [1:0]  k);
        logic [7:0] r;
        case (k)
            2'd0:    r = w[7:0];
            2'd1:    r = w[15:8];
            2'd2:    r = w[23:16];
            default: r = w[31:24];
        endcase
        return r;
    endfunction

    assign in_ready = ENB & ~pend_v_q;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        n_d         = n_q;
        pend_d      = pend_q;
        pend_n_d    = pend_n_q;
        pend_v_d    = pend_v_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        bit_d       = bit_q;

        if (ENB) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d     = ST_BUSY;
                        cur_d       = in_data;
                        n_d         = last_idx(PCLK);
                        out_data_d  = in_data[7:0];
                        out_valid_d = 1'b1;
                        bit_d       = 2'd0;
                    end
                end
                ST_BUSY: begin
                    if (bit_q != n_q) begin
                        bit_d      = bit_q + 2'd1;
                        out_data_d = byte_sel(cur_q, bit_q + 2'd1);
                        if (accept) begin
                            pend_d   = in_data;
                            pend_n_d = last_idx(PCLK);
                            pend_v_d = 1'b1;
                        end
                    end else if (pend_v_q) begin
                        // Pending word takes over with no idle cycle.
                        cur_d      = pend_q;
                        n_d        = pend_n_q;
                        out_data_d = pend_q[7:0];
                        bit_d      = 2'd0;
                        pend_v_d   = accept;
                        if (accept) begin
                            pend_d   = in_data;
                            pend_n_d = last_idx(PCLK);
                        end
                    end else if (accept) begin
                        // Last byte and empty slot: load straight into cur.
                        cur_d      = in_data;
                        n_d        = last_idx(PCLK);
                        out_data_d = in_data[7:0];
                        bit_d      = 2'd0;
                    end else begin
                        // Drain finished; out_data and bit keep last values.
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            n_q         <= '0;
            pend_q      <= '0;
            pend_n_q    <= '0;
            pend_v_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            bit_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            n_q         <= n_d;
            pend_q      <= pend_d;
            pend_n_q    <= pend_n_d;
            pend_v_q    <= pend_v_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            bit_q       <= bit_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_bit   = bit_q;

`ifdef CONV328_PARIDAD_EN
    logic par_q, par_d;

    // Follows out_data_d, so it holds whenever the byte holds.
    always_comb begin
        par_d = ^out_data_d;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign out_par = par_q;
`endif

endmodule

// File: tb/tb_convertidor_32a8.sv
// tb_convertidor_32a8: scoreboard bench for convertidor_32a8.
// Expected bytes are queued when a word is driven and popped as bytes are consumed.
module tb_convertidor_32a8;

    logic        CLK;
    logic        RESET;
    logic        ENB;
    logic [1:0]  PCLK;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [1:0]  out_bit;
`ifdef CONV328_PARIDAD_EN
    logic        out_par;
`endif

    int checks = 0;
    int errors = 0;
    int run_len = 0;
    int max_run = 0;
    logic [9:0] sb[$];

    convertidor_32a8 dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENB      (ENB),
        .PCLK     (PCLK),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_bit  (out_bit)
`ifdef CONV328_PARIDAD_EN
        ,
        .out_par  (out_par)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Consumer: a byte is taken on a cycle where out_valid and ENB are both high.
    always @(negedge CLK) begin
        logic [9:0] exp_v;
        if (!RESET && ENB && out_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_extra got %h bit %0d want nothing",
                         out_data, out_bit);
            end else begin
                exp_v = sb.pop_front();
                if ({out_bit, out_data} !== exp_v) begin
                    errors++;
                    $display("FAIL sb_byte got %h bit %0d want %h bit %0d",
                             out_data, out_bit, exp_v[7:0], exp_v[9:8]);
                end
`ifdef CONV328_PARIDAD_EN
                checks++;
                if (out_par !== ^exp_v[7:0]) begin
                    errors++;
                    $display("FAIL sb_par got %0d want %0d",
                             out_par, ^exp_v[7:0]);
                end
`endif
            end
        end else begin
            run_len = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Drive one word until it is taken; its bytes are queued up front.
    task automatic send(input logic [31:0] w, input logic [1:0] p);
        int   nb;
        logic hs;
        logic done;
        logic [1:0] kk;
        in_data  = w;
        PCLK     = p;
        in_valid = 1'b1;
        nb = (p == 2'b00) ? 1 : (p == 2'b01) ? 2 : 4;
        for (int k = 0; k < nb; k++) begin
            kk = k[1:0];
            sb.push_back({kk, w[8*k +: 8]});
        end
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge CLK);
            hs = in_ready;
            @(posedge CLK);
            #1;
            if (hs) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout word %h got no handshake want one", w);
        end
    endtask

    task automatic test_reset();
        RESET    = 1'b1;
        ENB      = 1'b1;
        PCLK     = 2'b00;
        in_data  = '0;
        in_valid = 1'b0;
        wait_cycles(2);
        checks++;
        if ({out_valid, out_bit, out_data} !== 11'd0) begin
            errors++;
            $display("FAIL reset_out got %b %0d %h want 0 0 00",
                     out_valid, out_bit, out_data);
        end
`ifdef CONV328_PARIDAD_EN
        checks++;
        if (out_par !== 1'b0) begin
            errors++;
            $display("FAIL reset_par got %0d want 0", out_par);
        end
`endif
        RESET = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_enb1 got %0d want 1", in_ready);
        end
        ENB = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_enb0 got %0d want 0", in_ready);
        end
        ENB = 1'b1;
        wait_cycles(1);
    endtask

    task automatic test_lsb_first();
        max_run = 0;
        send(32'hDDCCBBAA, 2'b10);
        idle();
        wait_cycles(4);
        checks++;
        if ({out_valid, out_bit, out_data} !== {1'b0, 2'd3, 8'hDD}) begin
            errors++;
            $display("FAIL w4_end got %b %0d %h want 0 3 dd",
                     out_valid, out_bit, out_data);
        end
        checks++;
        if (max_run != 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL w4_run got %0d left %0d want 4 left 0",
                     max_run, sb.size());
        end
    endtask

    task automatic test_two_byte();
        max_run = 0;
        send(32'h00001234, 2'b01);
        send(32'h00005678, 2'b01);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL pend_full_ready got %0d want 0", in_ready);
        end
        idle();
        wait_cycles(3);
        checks++;
        if (out_valid !== 1'b0 || max_run != 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL w2_run got v%0d run %0d left %0d want v0 run 4 left 0",
                     out_valid, max_run, sb.size());
        end
    endtask

    task automatic test_one_byte();
        max_run = 0;
        send(32'h11, 2'b00);
        send(32'h22, 2'b00);
        send(32'h33, 2'b00);
        send(32'h44, 2'b00);
        idle();
        wait_cycles(1);
        checks++;
        if (out_valid !== 1'b0 || out_bit !== 2'd0 || out_data !== 8'h44) begin
            errors++;
            $display("FAIL w1_end got %b %0d %h want 0 0 44",
                     out_valid, out_bit, out_data);
        end
        checks++;
        if (max_run != 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL w1_run got %0d left %0d want 4 left 0",
                     max_run, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        max_run = 0;
        send(32'h04030201, 2'b10);
        send(32'h08070605, 2'b10);
        send(32'h0C0B0A09, 2'b10);
        idle();
        wait_cycles(12);
        checks++;
        if (max_run != 12 || sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_run got %0d left %0d v%0d want 12 left 0 v0",
                     max_run, sb.size(), out_valid);
        end
    endtask

    task automatic test_mixed_width();
        max_run = 0;
        send(32'h44332211, 2'b10);
        send(32'h000000AA, 2'b00);
        send(32'h0000CCBB, 2'b01);
        idle();
        wait_cycles(6);
        checks++;
        if (max_run != 7 || sb.size() != 0) begin
            errors++;
            $display("FAIL mixed_run got %0d left %0d want 7 left 0",
                     max_run, sb.size());
        end
        max_run = 0;
        send(32'h87654321, 2'b11);
        idle();
        wait_cycles(5);
        checks++;
        if (max_run != 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL rsvd_run got %0d left %0d want 4 left 0",
                     max_run, sb.size());
        end
    endtask

    task automatic test_stall();
        send(32'hDDCCBBAA, 2'b10);
        idle();
        wait_cycles(1);
        ENB = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_cycles(1);
            checks++;
            if ({out_valid, out_bit, out_data, in_ready} !==
                {1'b1, 2'd1, 8'hBB, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold got v%0d %0d %h r%0d want v1 1 bb r0",
                         out_valid, out_bit, out_data, in_ready);
            end
        end
        ENB = 1'b1;
        wait_cycles(1);
        checks++;
        if (out_data !== 8'hCC || out_bit !== 2'd2) begin
            errors++;
            $display("FAIL stall_resume got %h %0d want cc 2", out_data, out_bit);
        end
        wait_cycles(3);
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain got left %0d v%0d want 0 v0",
                     sb.size(), out_valid);
        end
    endtask

    task automatic test_reset_mid();
        send(32'hDDCCBBAA, 2'b10);
        idle();
        wait_cycles(2);
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_bit, out_data} !== 11'd0) begin
            errors++;
            $display("FAIL async_rst got %b %0d %h want 0 0 00",
                     out_valid, out_bit, out_data);
        end
        sb.delete();
        wait_cycles(1);
        RESET = 1'b0;
        #1;
        checks++;
        if (in_ready !== ENB) begin
            errors++;
            $display("FAIL rst_ready got %0d want %0d", in_ready, ENB);
        end
        max_run = 0;
        wait_cycles(6);
        checks++;
        if (max_run != 0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_no_dd got run %0d v%0d %h want 0 v0 00",
                     max_run, out_valid, out_data);
        end
    endtask

`ifdef CONV328_PARIDAD_EN
    task automatic test_parity();
        send(32'h00000703, 2'b01);
        idle();
        checks++;
        if (out_par !== 1'b0) begin
            errors++;
            $display("FAIL par_03 got %0d want 0", out_par);
        end
        wait_cycles(1);
        checks++;
        if (out_par !== 1'b1) begin
            errors++;
            $display("FAIL par_07 got %0d want 1", out_par);
        end
        wait_cycles(2);
    endtask
`endif

    initial begin
        test_reset();
        test_lsb_first();
        test_two_byte();
        test_one_byte();
        test_back_to_back();
        test_mixed_width();
        test_stall();
        test_reset_mid();
`ifdef CONV328_PARIDAD_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/convertidor_32a8.md
CONVERTIDOR_32A8 -- requirements
Module: convertidor_32a8

Interface
REQ-001 No parameters; byte count per word is selected at run time by PCLK.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 ENB  input  1  stage enable; low = full stall, all state held.
REQ-005 PCLK  input  2  width select: 00 = 1 byte/word, 01 = 2, 10 = 4, 11 = 4 (reserved, treated as 10).
REQ-006 in_data  input  32  parallel word from the 8-to-32 packer / link layer; byte k = in_data[8k+7:8k].
REQ-007 in_valid  input  1  in_data holds a word.
REQ-008 in_ready  output  1  combinational: ENB & ~pend_v.
REQ-009 out_data  output  8  registered byte to the serializer.
REQ-010 out_valid  output  1  registered; out_data carries a valid byte this cycle.
REQ-011 bit  output  2  registered index k of the byte on out_data.

Function
REQ-012 The block SHALL accept a word on any edge where in_valid & in_ready; PCLK SHALL be sampled with that word and held for that word's lifetime.
REQ-013 Byte order SHALL be LSB first: byte 0, 1, ... up to N-1 (N = 1, 2 or 4), one byte per enabled cycle, matching the packing order of the 8-to-32 stage.
REQ-014 Storage SHALL be one current-word register (cur, n, busy) plus one pending slot (pend, pend_n, pend_v).
REQ-015 Latency SHALL be 1 cycle: a word accepted at edge E while idle SHALL present byte 0 with out_valid=1, bit=0 after edge E.
REQ-016 Busy, not on last byte: each enabled edge SHALL advance bit by 1 and present the next byte; an accepted word SHALL go to the pending slot.
REQ-017 Busy, on last byte, pend_v=1: the next edge SHALL move pend to cur and present its byte 0 (no gap); a word accepted on that same edge SHALL refill the pending slot.
REQ-018 Busy, on last byte, pend_v=0, word accepted that edge: the new word SHALL load into cur directly and present byte 0 (no gap).
REQ-019 Busy, on last byte, nothing available: next edge SHALL clear out_valid and busy; out_data and bit SHALL hold their last values.
REQ-020 ENB=0 SHALL freeze all registers; in_ready SHALL be 0; out_valid SHALL hold its value and the consumer SHALL ignore it while ENB=0.
REQ-021 Back-to-back 4-byte words with in_valid held high SHALL give continuous out_valid=1 at one byte per cycle.

Reset
REQ-022 RESET high SHALL immediately force out_data=8'h00, out_valid=0, bit=0, busy=0, pend_v=0 and clear cur/pend, independent of CLK and ENB.
REQ-023 After RESET deasserts, in_ready SHALL equal ENB; a reset mid-word SHALL discard current and pending words with no partial byte emitted afterwards.

Configuration
REQ-024 Macro CONV328_PARIDAD_EN: when defined, an extra output out_par (1 bit) SHALL be the registered even parity (XOR) of the byte loaded into out_data, updated on the same edge and reset to 0.
REQ-025 Without CONV328_PARIDAD_EN the port out_par and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 Reset, then PCLK=10, word 32'hDDCCBBAA for one cycle -> out_data AA,BB,CC,DD on 4 consecutive cycles, bit 0..3, out_valid then drops.
REQ-027 PCLK=01, words 32'h00001234 and 32'h00005678 back to back -> bytes 34,12,78,56 with no gap; in_ready low once the pending slot is full.
REQ-028 PCLK=00, four words 32'h11,22,33,44 held valid -> 11,22,33,44 one per cycle, bit=0 throughout.
REQ-029 PCLK=10, ENB low for 3 cycles after byte BB -> out_data stays BB, bit=1, in_ready=0; resumes with CC on the first enabled edge.
REQ-030 RESET asserted between clock edges while presenting CC -> outputs 0 immediately; no DD emitted after release.
REQ-031 With CONV328_PARIDAD_EN, bytes 8'h03 and 8'h07 -> out_par 0 then 1.
